sap_control_unit: RTL and testbench
===================================

Name: sap_control_unit

Overview:
- Control sequencer for the SAP datapath: ring-counter T-states plus opcode decode.
- Drives the control word for PC, MAR, RAM, IR, accumulator, B register, output register and the ALU (alu1/alu0/add_sub/xor_not/alu_out).
- Sits between the instruction register's opcode field and every load/enable strobe in the processor.

Parameters:
- OPW, 4, opcode width (IR upper field).
- FAST_END, 0, when 1 an instruction returns to T1 right after its last active T-state; when 0 every instruction takes 6 T-states.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  OPW  IR opcode field; valid from T4 onward.
- zero_flag  in  1  accumulator==0 flag (used only with the optional feature).
- pc_out, pc_inc, pc_load  out  1 each  PC to bus / increment / load from bus.
- mar_load, ram_out, ir_load, ir_out  out  1 each  MAR load / RAM to bus / IR load / IR address field to bus.
- acc_load, acc_out, b_load, out_load  out  1 each  register strobes.
- alu1, alu0, add_sub, xor_not, alu_out  out  1 each  ALU controls.
- tstate  out  3  current T-state, 1..6 (0 when halted).
- halted  out  1  high after HLT.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state=T1 and halted=0. While rst=1, every control output is 0, alu1/alu0=00, add_sub=0, xor_not=0, alu_out=0. Reset mid-instruction aborts it; fetch restarts at T1 on the first edge after release.
- State register: T1..T6, HALT. Outputs are a combinational decode of state and opcode; each strobe is one cycle wide.
- Fetch (all opcodes):
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute, opcode map:
  - 0 LDA: T4 ir_out, mar_load; T5 ram_out, acc_load; T6 idle.
  - 1 ADD / 2 SUB / 3 AND / 4 OR / 5 XOR:
    - T4 ir_out, mar_load.
    - T5 ram_out, b_load; ALU select driven.
    - T6 ALU select held, alu_out, acc_load.
  - 6 NOT: T4 select alu1=1, alu0=1, xor_not=1; T5 same select plus alu_out, acc_load; T6 idle.
  - 14 OUT: T4 acc_out, out_load.
  - 15 HLT: T4 -> HALT. In HALT all strobes are 0, halted=1, tstate=0; only rst exits.
  - Any other opcode: NOP, execute states idle.
- ALU selects:
  - ADD=00/add_sub 0; SUB=00/add_sub 1; AND=01; OR=10; XOR=11/xor_not 0.
  - The ALU recomputes only on select changes, so selects must be stable at least one full cycle before alu_out rises and held through it.
  - alu_out and acc_out are never high in the same cycle. At most one bus driver (pc_out, ram_out, ir_out, acc_out, alu_out) is high per cycle.
- Sequencing:
  - FAST_END=0: T6 -> T1 always.
  - FAST_END=1: LDA exits after T5; NOT exits after T5; OUT and NOP exit after T4; ALU ops still use T6.
- Outside the listed cycles, all ALU controls are 0.

Optional Feature:
- Macro SAP_JUMP_EN enables branch opcodes:
  - 7 JMP: T4 ir_out, pc_load.
  - 8 JZ: T4 ir_out, pc_load only if zero_flag=1 at T4, otherwise idle.
  - Both are treated as ending at T4 when FAST_END=1.
- Without the macro, opcodes 7 and 8 decode as NOP and pc_load is tied to 0.

Decomposition:
- Package sap_pkg holds:
  - opcode constants (OP_LDA..OP_HLT, OP_JMP, OP_JZ);
  - T-state enum (T1..T6, HALT);
  - ALU select constants (ALU_ADD=2'b00, ALU_AND, ALU_OR, ALU_XN).
- One natural sub-module, sap_ring_counter: T-state advance, early-end input, halt input, async reset.

Test Plan:
- Reset, then opcode=0 (LDA), FAST_END=0 -> T1 pc_out+mar_load, T2 pc_inc, T3 ram_out+ir_load, T4 ir_out+mar_load, T5 ram_out+acc_load, T6 no strobes, then T1.
- opcode=2 (SUB) -> T5 b_load with alu1/alu0=00, add_sub=1; T6 alu_out+acc_load with the same selects; alu_out low in every other cycle.
- opcode=6 (NOT) -> T4 selects 11, xor_not=1, alu_out=0; T5 alu_out+acc_load; with FAST_END=1 next cycle is T1.
- opcode=15 (HLT) -> after T4 halted=1, tstate=0, no strobes for 20 cycles; rst pulse -> halted=0, T1.
- Assert rst asynchronously mid-T5 of ADD -> outputs 0 immediately; after release, fetch from T1.
- SAP_JUMP_EN, opcode=8: zero_flag=1 -> pc_load+ir_out at T4; zero_flag=0 -> no pc_load. Without the macro, opcode 7 gives no pc_load.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes, T-state encoding and ALU select constants for the SAP control unit
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Encoding doubles as the tstate output: T1..T6 read as 1..6, HALT as 0.
    typedef enum logic [2:0] {
        HALT = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6
    } tstate_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_XN  = 2'b11;

    // {alu1, alu0} for the two-operand ALU opcodes; ADD and SUB share the adder.
    function automatic logic [1:0] alu_sel_f(input logic [3:0] op);
        case (op)
            OP_AND:  alu_sel_f = ALU_AND;
            OP_OR:   alu_sel_f = ALU_OR;
            OP_XOR:  alu_sel_f = ALU_XN;
            default: alu_sel_f = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - T-state sequencer for the SAP control unit
// Ports: clk, rst (async, active-high); early_end returns to T1 after the
// current state; halt_req enters HALT; state is the current T-state.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    early_end,
    input  logic    halt_req,
    output tstate_e state
);

    tstate_e state_q;
    tstate_e state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == HALT) begin
            state_d = HALT;
        end else if (halt_req) begin
            state_d = HALT;
        end else if (state_q == T6 || early_end) begin
            state_d = T1;
        end else begin
            state_d = tstate_e'(state_q + 3'd1);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sap_control_unit.sv
// rtl/sap_control_unit.sv - SAP control sequencer: T-state ring counter plus opcode decode
// Ports: clk, rst (async, active-high), opcode (IR upper field), zero_flag;
// outputs are the one-cycle PC/MAR/RAM/IR/ACC/B/OUT strobes, ALU controls,
// tstate (1..6, 0 when halted) and halted.
// Optional macro SAP_JUMP_EN adds JMP (7) and JZ (8); without it they are NOPs
// and pc_load stays 0.
module sap_control_unit
    import sap_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int FAST_END = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero_flag,
    output logic           pc_out,
    output logic           pc_inc,
    output logic           pc_load,
    output logic           mar_load,
    output logic           ram_out,
    output logic           ir_load,
    output logic           ir_out,
    output logic           acc_load,
    output logic           acc_out,
    output logic           b_load,
    output logic           out_load,
    output logic           alu1,
    output logic           alu0,
    output logic           add_sub,
    output logic           xor_not,
    output logic           alu_out,
    output logic [2:0]     tstate,
    output logic           halted
);

    localparam bit FAST = (FAST_END != 0);

    tstate_e    state;
    logic       early_end;
    logic       halt_req;
    logic [1:0] alu_sel;

    sap_ring_counter u_ring (
        .clk       (clk),
        .rst       (rst),
        .early_end (early_end),
        .halt_req  (halt_req),
        .state     (state)
    );

`ifndef SAP_JUMP_EN
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
`endif

    // Decode is gated by rst so that every strobe reads 0 while reset is held,
    // even though the counter already sits in T1.
    always_comb begin
        pc_out    = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        mar_load  = 1'b0;
        ram_out   = 1'b0;
        ir_load   = 1'b0;
        ir_out    = 1'b0;
        acc_load  = 1'b0;
        acc_out   = 1'b0;
        b_load    = 1'b0;
        out_load  = 1'b0;
        alu_sel   = ALU_ADD;
        add_sub   = 1'b0;
        xor_not   = 1'b0;
        alu_out   = 1'b0;
        early_end = 1'b0;
        halt_req  = 1'b0;
        if (!rst) begin
            case (state)
                T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                T4, T5, T6: begin
                    case (opcode)
                        OPW'(OP_LDA): begin
                            if (state == T4) begin
                                ir_out   = 1'b1;
                                mar_load = 1'b1;
                            end else if (state == T5) begin
                                ram_out   = 1'b1;
                                acc_load  = 1'b1;
                                early_end = FAST;
                            end
                        end
                        OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND),
                        OPW'(OP_OR), OPW'(OP_XOR): begin
                            if (state == T4) begin
                                ir_out   = 1'b1;
                                mar_load = 1'b1;
                            end else begin
                                // Select is raised in T5 so the ALU has a full
                                // cycle to settle before alu_out in T6.
                                alu_sel = alu_sel_f(4'(opcode));
                                add_sub = (opcode == OPW'(OP_SUB));
                                if (state == T5) begin
                                    ram_out = 1'b1;
                                    b_load  = 1'b1;
                                end else begin
                                    alu_out  = 1'b1;
                                    acc_load = 1'b1;
                                end
                            end
                        end
                        OPW'(OP_NOT): begin
                            if (state != T6) begin
                                alu_sel = ALU_XN;
                                xor_not = 1'b1;
                            end
                            if (state == T5) begin
                                alu_out   = 1'b1;
                                acc_load  = 1'b1;
                                early_end = FAST;
                            end
                        end
                        OPW'(OP_OUT): begin
                            if (state == T4) begin
                                acc_out   = 1'b1;
                                out_load  = 1'b1;
                                early_end = FAST;
                            end
                        end
                        OPW'(OP_HLT): begin
                            halt_req = (state == T4);
                        end
`ifdef SAP_JUMP_EN
                        OPW'(OP_JMP): begin
                            if (state == T4) begin
                                ir_out    = 1'b1;
                                pc_load   = 1'b1;
                                early_end = FAST;
                            end
                        end
                        OPW'(OP_JZ): begin
                            if (state == T4) begin
                                ir_out    = zero_flag;
                                pc_load   = zero_flag;
                                early_end = FAST;
                            end
                        end
`endif
                        default: begin
                            early_end = FAST && (state == T4);
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign alu1   = alu_sel[1];
    assign alu0   = alu_sel[0];
    assign tstate = 3'(state);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_sap_control_unit.sv
// tb/tb_sap_control_unit.sv - directed self-checking bench for sap_control_unit
module tb_sap_control_unit;

    localparam logic [15:0] PC_OUT   = 16'h8000;
    localparam logic [15:0] PC_INC   = 16'h4000;
    localparam logic [15:0] PC_LOAD  = 16'h2000;
    localparam logic [15:0] MAR_LOAD = 16'h1000;
    localparam logic [15:0] RAM_OUT  = 16'h0800;
    localparam logic [15:0] IR_LOAD  = 16'h0400;
    localparam logic [15:0] IR_OUT   = 16'h0200;
    localparam logic [15:0] ACC_LOAD = 16'h0100;
    localparam logic [15:0] ACC_OUT  = 16'h0080;
    localparam logic [15:0] B_LOAD   = 16'h0040;
    localparam logic [15:0] OUT_LOAD = 16'h0020;
    localparam logic [15:0] ALU1     = 16'h0010;
    localparam logic [15:0] ALU0     = 16'h0008;
    localparam logic [15:0] ADD_SUB  = 16'h0004;
    localparam logic [15:0] XOR_NOT  = 16'h0002;
    localparam logic [15:0] ALU_OUT  = 16'h0001;
    localparam logic [15:0] NONE     = 16'h0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] opcode_f;
    logic       zero_flag;

    int checks = 0;
    int errors = 0;

    logic s_pc_out, s_pc_inc, s_pc_load, s_mar_load, s_ram_out, s_ir_load, s_ir_out;
    logic s_acc_load, s_acc_out, s_b_load, s_out_load, s_alu1, s_alu0, s_add_sub;
    logic s_xor_not, s_alu_out, s_halted;
    logic [2:0] s_tstate;
    logic f_pc_out, f_pc_inc, f_pc_load, f_mar_load, f_ram_out, f_ir_load, f_ir_out;
    logic f_acc_load, f_acc_out, f_b_load, f_out_load, f_alu1, f_alu0, f_add_sub;
    logic f_xor_not, f_alu_out, f_halted;
    logic [2:0] f_tstate;
    logic [15:0] s_ctrl, f_ctrl;

    assign s_ctrl = {s_pc_out, s_pc_inc, s_pc_load, s_mar_load, s_ram_out, s_ir_load,
                     s_ir_out, s_acc_load, s_acc_out, s_b_load, s_out_load, s_alu1,
                     s_alu0, s_add_sub, s_xor_not, s_alu_out};
    assign f_ctrl = {f_pc_out, f_pc_inc, f_pc_load, f_mar_load, f_ram_out, f_ir_load,
                     f_ir_out, f_acc_load, f_acc_out, f_b_load, f_out_load, f_alu1,
                     f_alu0, f_add_sub, f_xor_not, f_alu_out};

    always #5 clk = ~clk;

    sap_control_unit #(.OPW(4), .FAST_END(0)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag),
        .pc_out(s_pc_out), .pc_inc(s_pc_inc), .pc_load(s_pc_load),
        .mar_load(s_mar_load), .ram_out(s_ram_out), .ir_load(s_ir_load),
        .ir_out(s_ir_out), .acc_load(s_acc_load), .acc_out(s_acc_out),
        .b_load(s_b_load), .out_load(s_out_load), .alu1(s_alu1), .alu0(s_alu0),
        .add_sub(s_add_sub), .xor_not(s_xor_not), .alu_out(s_alu_out),
        .tstate(s_tstate), .halted(s_halted)
    );

    sap_control_unit #(.OPW(4), .FAST_END(1)) dut_fast (
        .clk(clk), .rst(rst_f), .opcode(opcode_f), .zero_flag(zero_flag),
        .pc_out(f_pc_out), .pc_inc(f_pc_inc), .pc_load(f_pc_load),
        .mar_load(f_mar_load), .ram_out(f_ram_out), .ir_load(f_ir_load),
        .ir_out(f_ir_out), .acc_load(f_acc_load), .acc_out(f_acc_out),
        .b_load(f_b_load), .out_load(f_out_load), .alu1(f_alu1), .alu0(f_alu0),
        .add_sub(f_add_sub), .xor_not(f_xor_not), .alu_out(f_alu_out),
        .tstate(f_tstate), .halted(f_halted)
    );

    task automatic check(input string tag, input bit fast,
                         input logic [15:0] ec, input logic [2:0] et);
        logic [15:0] oc;
        logic [2:0]  ot;
        logic        oh;
        logic        eh;
        oc = fast ? f_ctrl : s_ctrl;
        ot = fast ? f_tstate : s_tstate;
        oh = fast ? f_halted : s_halted;
        eh = (et == 3'd0);
        checks++;
        assert (oc === ec && ot === et && oh === eh) else begin
            errors++;
            $error("FAIL %s: ctrl=%h tstate=%0d halted=%b, expected ctrl=%h tstate=%0d halted=%b",
                   tag, oc, ot, oh, ec, et, eh);
        end
    endtask

    // Check the current cycle, then move to one time unit after the next rising edge.
    task automatic cyc(input string tag, input bit fast,
                       input logic [15:0] ec, input logic [2:0] et);
        check(tag, fast, ec, et);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input bit fast);
        cyc({tag, "_t1"}, fast, PC_OUT | MAR_LOAD, 3'd1);
        cyc({tag, "_t2"}, fast, PC_INC, 3'd2);
        cyc({tag, "_t3"}, fast, RAM_OUT | IR_LOAD, 3'd3);
    endtask

    logic [3:0]  alu_ops [4];
    logic [15:0] alu_sels[4];

    initial begin
        alu_ops[0] = 4'd1; alu_sels[0] = NONE;
        alu_ops[1] = 4'd3; alu_sels[1] = ALU0;
        alu_ops[2] = 4'd4; alu_sels[2] = ALU1;
        alu_ops[3] = 4'd5; alu_sels[3] = ALU1 | ALU0;

        rst = 1'b1;
        rst_f = 1'b1;
        opcode = 4'd0;
        opcode_f = 4'd0;
        zero_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, NONE, 3'd1);
        check("reset_fast", 1'b1, NONE, 3'd1);

        rst = 1'b0;
        #1;
        fetch("lda", 1'b0);
        cyc("lda_t4", 1'b0, IR_OUT | MAR_LOAD, 3'd4);
        cyc("lda_t5", 1'b0, RAM_OUT | ACC_LOAD, 3'd5);
        cyc("lda_t6", 1'b0, NONE, 3'd6);

        opcode = 4'd2;
        fetch("sub", 1'b0);
        cyc("sub_t4", 1'b0, IR_OUT | MAR_LOAD, 3'd4);
        cyc("sub_t5", 1'b0, RAM_OUT | B_LOAD | ADD_SUB, 3'd5);
        cyc("sub_t6", 1'b0, ALU_OUT | ACC_LOAD | ADD_SUB, 3'd6);

        for (int i = 0; i < 4; i++) begin
            opcode = alu_ops[i];
            fetch("alu", 1'b0);
            cyc("alu_t4", 1'b0, IR_OUT | MAR_LOAD, 3'd4);
            cyc("alu_t5", 1'b0, RAM_OUT | B_LOAD | alu_sels[i], 3'd5);
            cyc("alu_t6", 1'b0, ALU_OUT | ACC_LOAD | alu_sels[i], 3'd6);
        end

        opcode = 4'd6;
        fetch("not", 1'b0);
        cyc("not_t4", 1'b0, ALU1 | ALU0 | XOR_NOT, 3'd4);
        cyc("not_t5", 1'b0, ALU1 | ALU0 | XOR_NOT | ALU_OUT | ACC_LOAD, 3'd5);
        cyc("not_t6", 1'b0, NONE, 3'd6);

        opcode = 4'd14;
        fetch("out", 1'b0);
        cyc("out_t4", 1'b0, ACC_OUT | OUT_LOAD, 3'd4);
        cyc("out_t5", 1'b0, NONE, 3'd5);
        cyc("out_t6", 1'b0, NONE, 3'd6);

        opcode = 4'd9;
        fetch("nop", 1'b0);
        cyc("nop_t4", 1'b0, NONE, 3'd4);
        cyc("nop_t5", 1'b0, NONE, 3'd5);
        cyc("nop_t6", 1'b0, NONE, 3'd6);

`ifdef SAP_JUMP_EN
        opcode = 4'd8;
        zero_flag = 1'b1;
        fetch("jz1", 1'b0);
        cyc("jz1_t4", 1'b0, IR_OUT | PC_LOAD, 3'd4);
        cyc("jz1_t5", 1'b0, NONE, 3'd5);
        cyc("jz1_t6", 1'b0, NONE, 3'd6);
        zero_flag = 1'b0;
        fetch("jz0", 1'b0);
        cyc("jz0_t4", 1'b0, NONE, 3'd4);
        cyc("jz0_t5", 1'b0, NONE, 3'd5);
        cyc("jz0_t6", 1'b0, NONE, 3'd6);
        opcode = 4'd7;
        fetch("jmp", 1'b0);
        cyc("jmp_t4", 1'b0, IR_OUT | PC_LOAD, 3'd4);
        cyc("jmp_t5", 1'b0, NONE, 3'd5);
        cyc("jmp_t6", 1'b0, NONE, 3'd6);
`else
        opcode = 4'd7;
        fetch("jmp_off", 1'b0);
        cyc("jmp_off_t4", 1'b0, NONE, 3'd4);
        cyc("jmp_off_t5", 1'b0, NONE, 3'd5);
        cyc("jmp_off_t6", 1'b0, NONE, 3'd6);
`endif

        opcode = 4'd1;
        fetch("add_rst", 1'b0);
        cyc("add_rst_t4", 1'b0, IR_OUT | MAR_LOAD, 3'd4);
        check("add_rst_t5", 1'b0, RAM_OUT | B_LOAD, 3'd5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 1'b0, NONE, 3'd1);
        @(posedge clk);
        #1;
        check("rst_held", 1'b0, NONE, 3'd1);
        rst = 1'b0;
        #1;
        fetch("after_rst", 1'b0);
        cyc("after_rst_t4", 1'b0, IR_OUT | MAR_LOAD, 3'd4);
        cyc("after_rst_t5", 1'b0, RAM_OUT | B_LOAD, 3'd5);
        cyc("after_rst_t6", 1'b0, ALU_OUT | ACC_LOAD, 3'd6);

        opcode = 4'd15;
        fetch("hlt", 1'b0);
        cyc("hlt_t4", 1'b0, NONE, 3'd4);
        for (int i = 0; i < 20; i++) begin
            cyc("halted", 1'b0, NONE, 3'd0);
        end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        cyc("unhalt_t1", 1'b0, PC_OUT | MAR_LOAD, 3'd1);
        check("unhalt_t2", 1'b0, PC_INC, 3'd2);

        rst_f = 1'b0;
        opcode_f = 4'd0;
        #1;
        fetch("f_lda", 1'b1);
        cyc("f_lda_t4", 1'b1, IR_OUT | MAR_LOAD, 3'd4);
        cyc("f_lda_t5", 1'b1, RAM_OUT | ACC_LOAD, 3'd5);
        opcode_f = 4'd6;
        fetch("f_not", 1'b1);
        cyc("f_not_t4", 1'b1, ALU1 | ALU0 | XOR_NOT, 3'd4);
        cyc("f_not_t5", 1'b1, ALU1 | ALU0 | XOR_NOT | ALU_OUT | ACC_LOAD, 3'd5);
        opcode_f = 4'd14;
        fetch("f_out", 1'b1);
        cyc("f_out_t4", 1'b1, ACC_OUT | OUT_LOAD, 3'd4);
        opcode_f = 4'd9;
        fetch("f_nop", 1'b1);
        cyc("f_nop_t4", 1'b1, NONE, 3'd4);
        opcode_f = 4'd1;
        fetch("f_add", 1'b1);
        cyc("f_add_t4", 1'b1, IR_OUT | MAR_LOAD, 3'd4);
        cyc("f_add_t5", 1'b1, RAM_OUT | B_LOAD, 3'd5);
        cyc("f_add_t6", 1'b1, ALU_OUT | ACC_LOAD, 3'd6);
        opcode_f = 4'd7;
        fetch("f_jmp", 1'b1);
`ifdef SAP_JUMP_EN
        cyc("f_jmp_t4", 1'b1, IR_OUT | PC_LOAD, 3'd4);
`else
        cyc("f_jmp_t4", 1'b1, NONE, 3'd4);
`endif
        check("f_back_t1", 1'b1, PC_OUT | MAR_LOAD, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
